// File: rtl/mips_pkg.sv
// Shared MIPS constants: R-type funct codes for the HI/LO unit, the
// multiply/divide FSM state type, and the default datapath width.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// Multiply/divide datapath: operand magnitudes, 2*WIDTH accumulator,
// one shift-add or restoring-subtract step per cycle, and final sign fix.
module md_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               bzero_q, bzero_d;

  logic               is_div, is_signed, rs_neg, rt_neg;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    is_div    = (funct == FN_DIV) || (funct == FN_DIVU);
    is_signed = (funct == FN_MULT) || (funct == FN_DIV);
    rs_neg    = is_signed & rs[WIDTH-1];
    rt_neg    = is_signed & rt[WIDTH-1];
    // Multiply: add the multiplicand into the upper half, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    // Divide: upper half is the partial remainder, lower half collects quotient bits.
    div_rem   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_diff  = div_rem - {1'b0, b_q};
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    if (load) begin
      a_d       = rs_neg ? -rs : rs;
      b_d       = rt_neg ? -rt : rt;
      acc_d     = '0;
      div_d     = is_div;
      neg_d     = rs_neg ^ rt_neg;
      rem_neg_d = rs_neg;
      bzero_d   = (rt == '0);
    end else if (step) begin
      if (div_q) begin
        acc_d = {(div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    product = neg_q ? -acc_q : acc_q;
    quot    = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // Divide by zero leaves the raw dividend as remainder; quotient is forced to all ones.
      lo_res = bzero_q ? '1 : (neg_q ? -quot : quot);
      hi_res = rem_neg_q ? -rem : rem;
    end else begin
      hi_res = product[2*WIDTH-1:WIDTH];
      lo_res = product[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit: owns HI/LO, sequences WIDTH
// iterations plus a sign-fix cycle, and stalls dependent HI/LO accesses.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [5:0]       funct_in,
  input  logic [WIDTH-1:0] RsData_in,
  input  logic [WIDTH-1:0] RtData_in,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] mf_data
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q;
  logic             md_op, mf_op, mt_op;
  logic             dp_load, dp_step;
  logic [WIDTH-1:0] hi_res, lo_res;

  always_comb begin
    md_op = req_valid && (funct_in == FN_MULT || funct_in == FN_MULTU ||
                          funct_in == FN_DIV  || funct_in == FN_DIVU);
    mf_op = req_valid && (funct_in == FN_MFHI || funct_in == FN_MFLO);
    mt_op = req_valid && (funct_in == FN_MTHI || funct_in == FN_MTLO);
    stall = (md_op || mf_op || mt_op) && (state_q != IDLE);
    if (mf_op && funct_in == FN_MFHI) begin
      mf_data = hi_q;
    end else if (mf_op) begin
      mf_data = lo_q;
    end else begin
      mf_data = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_op) begin
          dp_load = 1'b1;
          count_d = '0;
          state_d = CALC;
        end else if (mt_op) begin
          if (funct_in == FN_MTHI) begin
            hi_d = RsData_in;
          end else begin
            lo_d = RsData_in;
          end
        end
      end
      CALC: begin
        dp_step = 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      FIX: begin
        hi_d    = hi_res;
        lo_d    = lo_res;
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  md_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load),
    .step   (dp_step),
    .funct  (funct_in),
    .rs     (RsData_in),
    .rt     (RtData_in),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed HI/LO scenarios plus randomized instruction
// streams, checked each cycle against an arithmetic model with a busy countdown.
module tb_ex_muldiv;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [5:0]  funct_in;
  logic [31:0] RsData_in, RtData_in;
  logic        stall, busy;
  logic [31:0] hi_out, lo_out, mf_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;

  // model state
  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  // values sampled mid-cycle by drive()
  logic        stall_s, busy_s;
  logic [31:0] mf_s;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .funct_in  (funct_in),
    .RsData_in (RsData_in),
    .RtData_in (RtData_in),
    .stall     (stall),
    .busy      (busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .mf_data   (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [5:0] f);
    return f == FN_MULT || f == FN_MULTU || f == FN_DIV || f == FN_DIVU;
  endfunction

  function automatic bit is_hilo(input logic [5:0] f);
    return is_md(f) || f == FN_MFHI || f == FN_MFLO || f == FN_MTHI || f == FN_MTLO;
  endfunction

  // {HI, LO} straight from the arithmetic definition of each instruction
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] q, r;
    logic [63:0] res;
    res = '0;
    case (f)
      FN_MULT: begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'(sa * sb);
      end
      FN_MULTU: res = {32'd0, a} * {32'd0, b};
      FN_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      FN_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // One clock: apply inputs, sample outputs mid-cycle, advance model at the edge.
  task automatic drive(input logic r, input logic v, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    rst = r; req_valid = v; funct_in = f; RsData_in = a; RtData_in = b;
    #2;
    stall_s = stall; busy_s = busy; mf_s = mf_data;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_hi = '0; m_lo = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (v && is_md(f)) begin
      res = ref_md(f, a, b);
      p_hi = res[63:32]; p_lo = res[31:0];
      m_cnt = 33;
    end else if (v && f == FN_MTHI) begin
      m_hi = a;
    end else if (v && f == FN_MTLO) begin
      m_lo = a;
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'h00, 32'd0, 32'd0);
  endtask

  task automatic settle();
    for (int i = 0; i < 40 && m_cnt != 0; i++) idle();
    chk("settle_timeout", 64'(m_cnt), 64'd0);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    drive(1'b0, 1'b1, f, a, b);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("stall", 64'(stall), 64'(req_valid && is_hilo(funct_in) && m_cnt != 0));
      chk("hi_out", 64'(hi_out), 64'(m_hi));
      chk("lo_out", 64'(lo_out), 64'(m_lo));
      chk("mf_data", 64'(mf_data),
          64'(!req_valid ? 32'd0 : funct_in == FN_MFHI ? m_hi : funct_in == FN_MFLO ? m_lo : 32'd0));
    end
  end

  initial begin
    int          busy_cycles, stall_cycles, mf_seen;
    logic [31:0] specials [5];
    logic [5:0]  pool [8];
    logic [5:0]  f;
    logic [31:0] a, b;
    specials = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
    pool = '{FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};

    rst = 1'b1; req_valid = 1'b0; funct_in = '0; RsData_in = '0; RtData_in = '0;
    drive(1'b1, 1'b0, 6'h00, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 6'h00, 32'd0, 32'd0);
    chk_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi_out), 64'd0);
    chk("reset_lo", 64'(lo_out), 64'd0);

    // 1: MULTU max*max, busy exactly 33 cycles
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (busy_s) busy_cycles++;
    end
    chk("t1_busy_cycles", 64'(busy_cycles), 64'd33);
    chk("t1_hi", 64'(hi_out), 64'hFFFF_FFFE);
    chk("t1_lo", 64'(lo_out), 64'h0000_0001);

    // 2: MULT -3 * 5
    issue(FN_MULT, 32'hFFFF_FFFD, 32'd5);
    settle();
    chk("t2_hi", 64'(hi_out), 64'hFFFF_FFFF);
    chk("t2_lo", 64'(lo_out), 64'hFFFF_FFF1);

    // 3: DIV -7 / 2, then DIVU 7 / 0
    issue(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    settle();
    chk("t3_lo", 64'(lo_out), 64'hFFFF_FFFD);
    chk("t3_hi", 64'(hi_out), 64'hFFFF_FFFF);
    issue(FN_DIVU, 32'd7, 32'd0);
    settle();
    chk("t3z_lo", 64'(lo_out), 64'hFFFF_FFFF);
    chk("t3z_hi", 64'(hi_out), 64'd7);

    // 4: signed overflow
    issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    settle();
    chk("t4_lo", 64'(lo_out), 64'h8000_0000);
    chk("t4_hi", 64'(hi_out), 64'd0);

    // 5: MFLO right behind MULTU 6*7, with a MULT attempt while busy
    issue(FN_MULTU, 32'd6, 32'd7);
    stall_cycles = 0; mf_seen = 0;
    for (int i = 0; i < 40 && mf_seen == 0; i++) begin
      f = (i >= 10 && i <= 12) ? FN_MULT : FN_MFLO;
      drive(1'b0, 1'b1, f, 32'd2, 32'd3);
      if (stall_s) stall_cycles++;
      else begin
        mf_seen = 1;
        chk("t5_mf_data", 64'(mf_s), 64'd42);
      end
    end
    chk("t5_stall_cycles", 64'(stall_cycles), 64'd33);
    chk("t5_busy_after", 64'(busy), 64'd0);

    // 6: reset mid-CALC, then MTHI
    issue(FN_MULT, 32'd3, 32'd4);
    for (int i = 0; i < 11; i++) idle();
    drive(1'b1, 1'b0, 6'h00, 32'd0, 32'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_hi", 64'(hi_out), 64'd0);
    chk("t6_lo", 64'(lo_out), 64'd0);
    drive(1'b0, 1'b1, FN_MTHI, 32'h0000_1234, 32'd0);
    chk("t6_mthi_stall", 64'(stall_s), 64'd0);
    chk("t6_mthi_hi", 64'(hi_out), 64'h0000_1234);

    // random instruction stream
    for (int i = 0; i < 1500; i++) begin
      f = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : 6'($urandom());
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), f, a, b);
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
